// File: rtl/muntjac_fpu_divsqrt_iter.sv
// rtl/muntjac_fpu_divsqrt_iter.sv - iterative radix-2 significand divider / square root
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   request handshake
//   param_i                   2'b01 selects square root, anything else divide
//   a_i, b_i                  normalized significands (b_i unused for square root)
//   odd_i                     square root only: unbiased exponent is odd
//   kill_i                    abort, returns to idle on the next edge
//   out_valid_o / out_ready_i result handshake
//   q_o, sticky_o             quotient/root with guard and round bits, nonzero remainder

module muntjac_fpu_divsqrt_iter #(
    parameter int unsigned Width = 53
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       param_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             odd_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width+1:0] q_o,
    output logic             sticky_o
);

    // Remainder is sized for the square-root recurrence (rem <= 2*root, then two
    // radicand bits shifted in); the divider only ever needs Width+1 of it.
    localparam int unsigned RemW = Width + 5;
    localparam int unsigned RadW = 2 * Width + 4;
    localparam int unsigned CntW = $clog2(Width + 3);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_sqrt_q, is_sqrt_d;
    logic [Width-1:0]  b_q, b_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [RadW-1:0]   rad_q, rad_d;
    logic [Width+1:0]  root_q, root_d;
    logic [Width+1:0]  res_q, res_d;
    logic              sticky_q, sticky_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [RemW-1:0]   sel_rem;
    logic [RemW-1:0]   sel_trial;
    logic [RemW-1:0]   diff;
    logic [RemW-1:0]   rem_step;
    logic [Width+1:0]  root_step;
    logic              res_bit;
    logic              sticky_step;

    always_comb begin
        // One restoring step shared by both operations. For square root the
        // trial subtrahend is 4*root+1 and two radicand bits enter per step;
        // for divide the remainder is already pre-shifted and compared to b.
        if (is_sqrt_q) begin
            sel_rem   = {rem_q[RemW-3:0], rad_q[RadW-1 -: 2]};
            sel_trial = RemW'({root_q, 2'b01});
        end else begin
            sel_rem   = rem_q;
            sel_trial = RemW'(b_q);
        end
        res_bit   = (sel_rem >= sel_trial);
        diff      = res_bit ? (sel_rem - sel_trial) : sel_rem;
        rem_step  = is_sqrt_q ? diff : {diff[RemW-2:0], 1'b0};
        root_step = {root_q[Width:0], res_bit};
        // With b=0 the remainder grows past the register and may truncate to
        // zero, so the divide-by-zero sticky is forced.
        sticky_step = (diff != '0) || (!is_sqrt_q && (b_q == '0));

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_sqrt_d = is_sqrt_q;
        b_d       = b_q;
        rem_d     = rem_q;
        rad_d     = rad_q;
        root_d    = root_q;
        res_d     = res_q;
        sticky_d  = sticky_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i && !kill_i) begin
                    state_d   = StBusy;
                    cnt_d     = CntW'(Width + 2);
                    is_sqrt_d = (param_i == 2'b01);
                    b_d       = b_i;
                    rem_d     = (param_i == 2'b01) ? '0 : RemW'(a_i);
                    // Radicand a*2^(Width+3+odd) laid out MSB-aligned in 2*Width+4 bits.
                    rad_d     = odd_i ? {a_i, {(Width + 4){1'b0}}}
                                      : {1'b0, a_i, {(Width + 3){1'b0}}};
                    root_d    = '0;
                end
            end
            StBusy: begin
                rem_d  = rem_step;
                rad_d  = {rad_q[RadW-3:0], 2'b00};
                root_d = root_step;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d  = StDone;
                    res_d    = root_step;
                    sticky_d = sticky_step;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (kill_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_sqrt_q   <= 1'b0;
            b_q         <= '0;
            rem_q       <= '0;
            rad_q       <= '0;
            root_q      <= '0;
            res_q       <= '0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_sqrt_q   <= is_sqrt_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            rad_q       <= rad_d;
            root_q      <= root_d;
            res_q       <= res_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign q_o         = res_q;
    assign sticky_o    = sticky_q;

endmodule

// File: tb/tb_muntjac_fpu_divsqrt_iter.sv
// tb/tb_muntjac_fpu_divsqrt_iter.sv - directed bench for muntjac_fpu_divsqrt_iter at widths 4, 8, 24, 53

module tb_muntjac_fpu_divsqrt_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  param;
    logic        odd;
    logic [52:0] a_v, b_v;
    logic [3:0]  vld, kill, ordy, irdy, oval, stk;
    logic [5:0]  q4;
    logic [9:0]  q8;
    logic [25:0] q24;
    logic [54:0] q53;
    logic [55:0] qo [4];

    assign qo[0] = 56'(q4);
    assign qo[1] = 56'(q8);
    assign qo[2] = 56'(q24);
    assign qo[3] = 56'(q53);

    int checks = 0;
    int errors = 0;

    muntjac_fpu_divsqrt_iter #(.Width(4)) u_w4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vld[0]), .in_ready_o(irdy[0]),
        .param_i(param), .a_i(a_v[3:0]), .b_i(b_v[3:0]), .odd_i(odd), .kill_i(kill[0]),
        .out_valid_o(oval[0]), .out_ready_i(ordy[0]), .q_o(q4), .sticky_o(stk[0])
    );
    muntjac_fpu_divsqrt_iter #(.Width(8)) u_w8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vld[1]), .in_ready_o(irdy[1]),
        .param_i(param), .a_i(a_v[7:0]), .b_i(b_v[7:0]), .odd_i(odd), .kill_i(kill[1]),
        .out_valid_o(oval[1]), .out_ready_i(ordy[1]), .q_o(q8), .sticky_o(stk[1])
    );
    muntjac_fpu_divsqrt_iter #(.Width(24)) u_w24 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vld[2]), .in_ready_o(irdy[2]),
        .param_i(param), .a_i(a_v[23:0]), .b_i(b_v[23:0]), .odd_i(odd), .kill_i(kill[2]),
        .out_valid_o(oval[2]), .out_ready_i(ordy[2]), .q_o(q24), .sticky_o(stk[2])
    );
    muntjac_fpu_divsqrt_iter #(.Width(53)) u_w53 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(vld[3]), .in_ready_o(irdy[3]),
        .param_i(param), .a_i(a_v), .b_i(b_v), .odd_i(odd), .kill_i(kill[3]),
        .out_valid_o(oval[3]), .out_ready_i(ordy[3]), .q_o(q53), .sticky_o(stk[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance s, wait for the result, hold it for
    // 'stall' cycles, then consume it and confirm the return to idle.
    task automatic run_op(input int s, input logic [1:0] p, input logic [52:0] a,
                          input logic [52:0] b, input logic od, input int stall,
                          input logic [55:0] exp_q, input logic exp_st,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        param = p; a_v = a; b_v = b; odd = od; vld[s] = 1'b1;
        chk({tag, "_in_ready"}, 64'(irdy[s]), 64'd1);
        @(negedge clk);
        vld[s] = 1'b0; a_v = ~a; b_v = ~b; param = ~p; odd = ~od;
        lat = 1;
        while (!oval[s] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, 64'(qo[s]), 64'(exp_q));
        chk({tag, "_sticky"}, 64'(stk[s]), 64'(exp_st));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(oval[s]), 64'd1);
            chk({tag, "_hold_q"}, 64'(qo[s]), 64'(exp_q));
            chk({tag, "_hold_sticky"}, 64'(stk[s]), 64'(exp_st));
        end
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        chk({tag, "_valid_drop"}, 64'(oval[s]), 64'd0);
        chk({tag, "_ready_back"}, 64'(irdy[s]), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int acc [4];
        int vcy [4];
        logic [55:0] rq [4];
        logic rs [4];
        int na;
        int nv;

        rst = 1'b1; param = 2'b00; odd = 1'b0; a_v = '0; b_v = '0;
        vld = '0; kill = '0; ordy = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk("reset_in_ready", 64'(irdy[s]), 64'd1);
            chk("reset_out_valid", 64'(oval[s]), 64'd0);
            chk("reset_q", 64'(qo[s]), 64'd0);
            chk("reset_sticky", 64'(stk[s]), 64'd0);
        end

        // Width 4
        run_op(0, 2'b00, 53'd8, 53'd12, 1'b0, 3, 56'd21, 1'b1, 7, "w4_div_8_12");
        run_op(0, 2'b01, 53'd8, 53'd0, 1'b0, 0, 56'd32, 1'b0, 7, "w4_sqrt_even");
        run_op(0, 2'b01, 53'd8, 53'd5, 1'b1, 0, 56'd45, 1'b1, 7, "w4_sqrt_odd");
        run_op(0, 2'b10, 53'd8, 53'd12, 1'b1, 0, 56'd21, 1'b1, 7, "w4_param2_div");

        // Width 53
        run_op(3, 2'b00, 53'd1 << 52, 53'd1 << 52, 1'b0, 0, 56'd1 << 54, 1'b0, 56, "w53_div_eq");
        run_op(3, 2'b00, {53{1'b1}}, 53'd1 << 52, 1'b0, 0, (56'd1 << 55) - 56'd4, 1'b0, 56, "w53_div_max");

        // Width 24
        run_op(2, 2'b00, 53'h800000, 53'hC00000, 1'b0, 0, 56'd22369621, 1'b1, 27, "w24_div_third");
        run_op(2, 2'b01, 53'h800000, 53'd0, 1'b0, 0, 56'd1 << 25, 1'b0, 27, "w24_sqrt_even");
        run_op(2, 2'b01, 53'h800000, 53'd0, 1'b1, 0, 56'd47453132, 1'b1, 27, "w24_sqrt_odd");
        run_op(2, 2'b00, 53'h800000, 53'd0, 1'b0, 0, 56'h3FFFFFF, 1'b1, 27, "w24_div_zero");

        // Width 8
        run_op(1, 2'b00, 53'd128, 53'd128, 1'b0, 0, 56'd512, 1'b0, 11, "w8_div_eq");
        run_op(1, 2'b00, 53'd255, 53'd128, 1'b0, 0, 56'd1020, 1'b0, 11, "w8_div_max");
        run_op(1, 2'b00, 53'd128, 53'd255, 1'b0, 0, 56'd257, 1'b1, 11, "w8_div_min");
        run_op(1, 2'b00, 53'd200, 53'd0, 1'b0, 0, 56'd1023, 1'b1, 11, "w8_div_zero");
        run_op(1, 2'b01, 53'd128, 53'd0, 1'b0, 0, 56'd512, 1'b0, 11, "w8_sqrt_even");
        run_op(1, 2'b01, 53'd128, 53'd0, 1'b1, 0, 56'd724, 1'b1, 11, "w8_sqrt_odd");
        run_op(1, 2'b01, 53'd255, 53'd0, 1'b0, 0, 56'd722, 1'b1, 11, "w8_sqrt_255");
        run_op(1, 2'b00, 53'd200, 53'd150, 1'b0, 0, 56'd682, 1'b1, 11, "w8_div_200_150");

        // Kill in BUSY cycle 3 on width 4
        @(negedge clk);
        param = 2'b00; a_v = 53'd8; b_v = 53'd12; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("kill_busy_ready", 64'(irdy[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        kill[0] = 1'b1;
        @(negedge clk);
        kill[0] = 1'b0;
        chk("kill_ready_next", 64'(irdy[0]), 64'd1);
        chk("kill_valid_next", 64'(oval[0]), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (oval[0]) cnt++;
        end
        chk("kill_no_valid", 64'(cnt), 64'd0);
        run_op(0, 2'b01, 53'd8, 53'd0, 1'b1, 0, 56'd45, 1'b1, 7, "w4_after_kill");

        // Back-to-back with in_valid held high on width 4
        na = 0; nv = 0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = -1; vcy[i] = -1; rq[i] = '0; rs[i] = 1'b0;
        end
        @(negedge clk);
        param = 2'b00; a_v = 53'd8; b_v = 53'd12; odd = 1'b0; vld[0] = 1'b1; ordy[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (irdy[0] && vld[0] && na < 4) begin acc[na] = c; na++; end
            if (oval[0] && nv < 4) begin vcy[nv] = c; rq[nv] = qo[0]; rs[nv] = stk[0]; nv++; end
            if (c == 1) begin a_v = 53'd12; b_v = 53'd8; end
            if (c == 9) vld[0] = 1'b0;
            @(negedge clk);
        end
        ordy[0] = 1'b0;
        chk("b2b_accept_count", 64'(na), 64'd2);
        chk("b2b_accept_0", 64'(acc[0]), 64'd0);
        chk("b2b_accept_1", 64'(acc[1]), 64'd8);
        chk("b2b_valid_count", 64'(nv), 64'd2);
        chk("b2b_valid_0", 64'(vcy[0]), 64'd7);
        chk("b2b_valid_1", 64'(vcy[1]), 64'd15);
        chk("b2b_q_0", 64'(rq[0]), 64'd21);
        chk("b2b_sticky_0", 64'(rs[0]), 64'd1);
        chk("b2b_q_1", 64'(rq[1]), 64'd48);
        chk("b2b_sticky_1", 64'(rs[1]), 64'd0);

        // Reset asserted mid-BUSY on width 8
        @(negedge clk);
        param = 2'b00; a_v = 53'd200; b_v = 53'd150; vld[1] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", 64'(irdy[1]), 64'd1);
        chk("rst_mid_valid", 64'(oval[1]), 64'd0);
        chk("rst_mid_q", 64'(qo[1]), 64'd0);
        chk("rst_mid_sticky", 64'(stk[1]), 64'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (oval[1]) cnt++;
        end
        chk("rst_mid_no_valid", 64'(cnt), 64'd0);
        run_op(1, 2'b00, 53'd128, 53'd255, 1'b0, 0, 56'd257, 1'b1, 11, "w8_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
